data_cache: RTL and testbench
=============================

// Module: data_cache
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate data cache between the memory-stage
//  load/store path and the byte-addressed data RAM. Load hits return in the same cycle.
//  Load misses stall the pipeline and refill one line word-by-word from the RAM.
//  Stores always pass straight through to the RAM, using the same sw/sh/sb strobes.
// PARAMETERS
//  ADDRESS_LENGTH  32  address and data width; RAM read/write words are 32 bits
//  SETS            16  number of lines; power of two
//  BLOCK_WORDS      4  32-bit words per line; power of two
// PORTS
//  clk         in   1   clock; all state updates on posedge
//  rst_n       in   1   asynchronous active-low reset
//  re          in   1   load request this cycle
//  sw/sh/sb    in   1   store word/half/byte request; one-hot; never asserted together with re
//  a           in   32  byte address of the request
//  wd          in   32  store data; byte0 = wd[7:0]
//  rd          out  32  load data {byte a+3, a+2, a+1, a}; unextended
//  stall       out  1   pipeline must hold re, a and strobes stable while high
//  mem_a       out  32  RAM byte address
//  mem_wd      out  32  RAM write data
//  mem_sw/sh/sb out 1   RAM store strobes
//  mem_rd      in   32  RAM combinational read data at mem_a
//  hit_count   out  32  load hits since reset; wraps
//  miss_count  out  32  load misses (refills started) since reset; wraps
// BEHAVIOUR
//  Address split (defaults): byte [1:0], word [3:2], set [7:4], tag [31:8].
//   Widths follow from log2(BLOCK_WORDS) and log2(SETS).
//  Storage: per line one valid bit, one tag, BLOCK_WORDS x 32-bit data words.
//  FSM states: IDLE, REFILL.
//   IDLE -> REFILL on a cacheable load miss.
//   REFILL -> IDLE after the last word is captured.
//  Cacheable load:
//   - A load is cacheable when all 4 bytes lie in one word, i.e. a[1:0]==0.
//   - Hit means valid[set] && tag match. On a hit in IDLE: rd = the addressed word,
//     stall=0, and hit_count increments at the clock edge.
//  Misaligned load (a[1:0]!=0): bypass the cache.
//   - mem_a=a and rd=mem_rd combinationally; stall=0.
//   - Neither counter changes and no line is touched.
//  Load miss:
//   - stall=1 combinationally in that cycle; miss_count increments.
//   - Clear valid[set] at the edge, then enter REFILL with word counter k=0.
//  REFILL:
//   - mem_a = {tag, set, k, 2'b00} each cycle; store strobes held 0.
//   - Capture mem_rd into word k at the edge, then k++.
//   - When k==BLOCK_WORDS-1: write the tag, set valid, and return to IDLE.
//   - stall=1 throughout REFILL.
//   - Next cycle (IDLE) the held request hits.
//   - Miss penalty is therefore BLOCK_WORDS+1 cycles from request to stall low.
//  Store (IDLE only):
//   - Same cycle: mem_a=a, mem_wd=wd, mem_sw/sh/sb = sw/sh/sb; stall=0.
//   - If a written byte's line is present (valid and tag match), update that byte at the
//     edge, honouring the write width (1, 2 or 4 bytes at a..a+n-1).
//   - If the written bytes span two lines: invalidate every present line touched;
//     do not update either.
//   - Miss: no allocate, cache unchanged. Counters unaffected by stores.
//  Idle (no request): mem_a=a; mem_wd=wd; mem_sw/sh/sb=0; stall=0.
//  Reset (async, any state, including mid-refill):
//   - All valid=0, state=IDLE, k=0, hit_count=0, miss_count=0.
//   - Outputs: stall=0; mem_sw/sh/sb=0.
//   - A partially refilled line is never left valid.
//   - Data/tag arrays are not reset.
//  Simultaneous events:
//   - The upstream block never asserts re with a store strobe; behaviour then is undefined.
//   - Requests arriving while in REFILL are the held stalled request and are ignored
//     until IDLE.
// TESTING
//  1. Reset, then load a=0x10000 (RAM words 0x11,0x22,0x33,0x44 at 0x10000..0x1000C)
//     -> stall high 5 cycles, then rd=0x11, hit_count=1, miss_count=1.
//  2. Load 0x10008 immediately after test 1 -> same-cycle hit, rd=0x33, stall=0,
//     hit_count=2.
//  3. sb a=0x10001 wd=0xAB on the cached line -> mem_sb=1 that cycle;
//     next load 0x10000 hits with rd=0x0000AB11.
//     sw to 0x20000 (uncached) -> no allocate; next load 0x20000 misses.
//  4. Load 0x10002 (misaligned) -> rd=mem_rd same cycle, stall=0, counters unchanged.
//     sh at 0x1000F spanning two lines -> both lines present become invalid.
//  5. Conflict: load 0x10000, then 0x10100 (same set, new tag), then 0x10000
//     -> three misses, miss_count=3, each rd correct.
//  6. Assert rst_n=0 in the third REFILL cycle -> stall=0 immediately;
//     after release, reload of same address misses again and returns correct data.

Source files
------------

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through no-write-allocate data cache with word-serial refill
module data_cache #(
    parameter int ADDRESS_LENGTH = 32,
    parameter int SETS           = 16,
    parameter int BLOCK_WORDS    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      re,
    input  logic                      sw,
    input  logic                      sh,
    input  logic                      sb,
    input  logic [ADDRESS_LENGTH-1:0] a,
    input  logic [ADDRESS_LENGTH-1:0] wd,
    output logic [ADDRESS_LENGTH-1:0] rd,
    output logic                      stall,
    output logic [ADDRESS_LENGTH-1:0] mem_a,
    output logic [ADDRESS_LENGTH-1:0] mem_wd,
    output logic                      mem_sw,
    output logic                      mem_sh,
    output logic                      mem_sb,
    input  logic [ADDRESS_LENGTH-1:0] mem_rd,
    output logic [31:0]               hit_count,
    output logic [31:0]               miss_count
);
    localparam int OFF_W      = $clog2(BLOCK_WORDS);
    localparam int SET_W      = $clog2(SETS);
    localparam int TAG_LSB    = OFF_W + SET_W + 2;
    localparam int TAG_W      = ADDRESS_LENGTH - TAG_LSB;
    localparam int LINE_W     = ADDRESS_LENGTH - OFF_W - 2;
    localparam int LINE_BYTES = BLOCK_WORDS * 4;
    localparam logic [OFF_W-1:0] K_LAST = OFF_W'(BLOCK_WORDS - 1);

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                      state_q, state_d;
    logic [OFF_W-1:0]            k;
    logic [SETS-1:0]             valid;
    logic [TAG_W-1:0]            tags [SETS];
    logic [ADDRESS_LENGTH-1:0]   data [SETS][BLOCK_WORDS];

    logic [SET_W-1:0]            set_idx;
    logic [OFF_W-1:0]            word_idx;
    logic [TAG_W-1:0]            req_tag;
    logic                        hit;
    logic                        store;
    logic [3:0]                  st_mask;
    logic [1:0]                  st_len_m1;
    logic                        st_span;
    logic [LINE_W-1:0]           last_line;
    logic                        last_present;
    logic [OFF_W+1:0]            st_off [4];
    logic                        do_hit, do_miss, do_store;

    assign set_idx  = a[TAG_LSB-1:OFF_W+2];
    assign word_idx = a[OFF_W+1:2];
    assign req_tag  = a[ADDRESS_LENGTH-1:TAG_LSB];
    assign hit      = valid[set_idx] && (tags[set_idx] == req_tag);
    assign store    = sw | sh | sb;

    // A store spans two lines when its last byte falls past the end of the line.
    always_comb begin
        st_mask   = sw ? 4'b1111 : (sh ? 4'b0011 : (sb ? 4'b0001 : 4'b0000));
        st_len_m1 = sw ? 2'd3 : (sh ? 2'd1 : 2'd0);
        st_span   = ({1'b0, a[OFF_W+1:0]} + (OFF_W+3)'(st_len_m1)) > (OFF_W+3)'(LINE_BYTES - 1);
        last_line = a[ADDRESS_LENGTH-1:OFF_W+2] + LINE_W'(st_span);
        last_present = valid[last_line[SET_W-1:0]] &&
                       (tags[last_line[SET_W-1:0]] == last_line[LINE_W-1:SET_W]);
        for (int i = 0; i < 4; i++) begin
            st_off[i] = a[OFF_W+1:0] + (OFF_W+2)'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        rd       = mem_rd;
        mem_a    = a;
        mem_wd   = wd;
        mem_sw   = 1'b0;
        mem_sh   = 1'b0;
        mem_sb   = 1'b0;
        do_hit   = 1'b0;
        do_miss  = 1'b0;
        do_store = 1'b0;
        case (state_q)
            IDLE: begin
                if (re && (a[1:0] == 2'b00)) begin
                    if (hit) begin
                        rd     = data[set_idx][word_idx];
                        do_hit = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        do_miss = 1'b1;
                        state_d = REFILL;
                    end
                end else if (store) begin
                    mem_sw   = sw;
                    mem_sh   = sh;
                    mem_sb   = sb;
                    do_store = 1'b1;
                end
            end
            REFILL: begin
                stall = 1'b1;
                mem_a = {a[ADDRESS_LENGTH-1:OFF_W+2], k, 2'b00};
                if (k == K_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset is asynchronous, so the held request must not leak a stall or a store.
        if (!rst_n) begin
            stall    = 1'b0;
            mem_sw   = 1'b0;
            mem_sh   = 1'b0;
            mem_sb   = 1'b0;
            do_hit   = 1'b0;
            do_miss  = 1'b0;
            do_store = 1'b0;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k          <= '0;
            valid      <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state_q <= state_d;
            if (do_hit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (do_miss) begin
                miss_count       <= miss_count + 32'd1;
                valid[set_idx]   <= 1'b0;
            end
            if (state_q == REFILL) begin
                k <= k + OFF_W'(1);
                if (k == K_LAST) begin
                    k              <= '0;
                    valid[set_idx] <= 1'b1;
                end
            end
            if (do_store && st_span) begin
                if (hit) begin
                    valid[set_idx] <= 1'b0;
                end
                if (last_present) begin
                    valid[last_line[SET_W-1:0]] <= 1'b0;
                end
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits alone guard them.
    always_ff @(posedge clk) begin
        if (state_q == REFILL) begin
            data[set_idx][k] <= mem_rd;
            if (k == K_LAST) begin
                tags[set_idx] <= req_tag;
            end
        end
        if (do_store && !st_span && hit) begin
            for (int i = 0; i < 4; i++) begin
                if (st_mask[i]) begin
                    data[set_idx][st_off[i][OFF_W+1:2]][{st_off[i][1:0], 3'b000} +: 8] <= wd[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - randomized self-checking bench for data_cache against a line-residency model
module tb_data_cache;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        re = 1'b0, sw = 1'b0, sh = 1'b0, sb = 1'b0;
    logic [31:0] a = '0, wd = '0;
    logic [31:0] rd, mem_a, mem_wd, mem_rd, hit_count, miss_count;
    logic        stall, mem_sw, mem_sh, mem_sb;

    logic [7:0]  ram [0:1048575];
    logic [27:0] res_line [16];
    bit          res_v [16];
    int          hit_m = 0, miss_m = 0;
    int          checks = 0, errors = 0;

    data_cache dut (
        .clk(clk), .rst_n(rst_n), .re(re), .sw(sw), .sh(sh), .sb(sb),
        .a(a), .wd(wd), .rd(rd), .stall(stall),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_sw(mem_sw), .mem_sh(mem_sh), .mem_sb(mem_sb),
        .mem_rd(mem_rd), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    assign mem_rd = {ram[20'(mem_a + 32'd3)], ram[20'(mem_a + 32'd2)],
                     ram[20'(mem_a + 32'd1)], ram[20'(mem_a)]};

    function automatic logic [31:0] ram_word(input logic [31:0] ad);
        return {ram[20'(ad + 32'd3)], ram[20'(ad + 32'd2)], ram[20'(ad + 32'd1)], ram[20'(ad)]};
    endfunction

    task automatic ram_put(input logic [31:0] ad, input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) ram[20'(ad + 32'(i))] = w[8*i +: 8];
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        for (int s = 0; s < 16; s++) res_v[s] = 1'b0;
        hit_m  = 0;
        miss_m = 0;
    endtask

    // Every load must return current RAM contents; residency decides only the latency.
    task automatic do_load(input logic [31:0] ad, output logic [31:0] got);
        int cyc;
        int s;
        bit hit_exp;
        @(negedge clk);
        re = 1'b1;
        a  = ad;
        #1;
        if (ad[1:0] != 2'b00) begin
            chk("mis_stall", 32'(stall), 32'd0);
            chk("mis_rd", rd, ram_word(ad));
            got = rd;
        end else begin
            s = int'(ad[7:4]);
            hit_exp = res_v[s] && (res_line[s] == ad[31:4]);
            cyc = 0;
            while (stall === 1'b1 && cyc < 20) begin
                cyc++;
                @(posedge clk);
                #1;
            end
            chk("stall_cycles", 32'(cyc), hit_exp ? 32'd0 : 32'd5);
            chk("load_rd", rd, ram_word(ad));
            got = rd;
            if (!hit_exp) begin
                miss_m++;
                res_v[s]    = 1'b1;
                res_line[s] = ad[31:4];
            end
            hit_m++;
        end
        @(posedge clk);
        #1;
        re = 1'b0;
        chk("hit_count", hit_count, 32'(hit_m));
        chk("miss_count", miss_count, 32'(miss_m));
    endtask

    task automatic do_store(input int kind, input logic [31:0] ad, input logic [31:0] data);
        int n;
        logic [27:0] lo, hi;
        n = (kind == 2) ? 4 : ((kind == 1) ? 2 : 1);
        @(negedge clk);
        a  = ad;
        wd = data;
        sw = (kind == 2);
        sh = (kind == 1);
        sb = (kind == 0);
        #1;
        chk("st_stall", 32'(stall), 32'd0);
        chk("st_mem_a", mem_a, ad);
        chk("st_mem_wd", mem_wd, data);
        chk("st_strobes", 32'({mem_sw, mem_sh, mem_sb}), 32'({kind == 2, kind == 1, kind == 0}));
        @(posedge clk);
        #1;
        sw = 1'b0;
        sh = 1'b0;
        sb = 1'b0;
        ram_put(ad, data, n);
        lo = ad[31:4];
        hi = 28'((ad + 32'(n - 1)) >> 4);
        if (lo != hi) begin
            if (res_v[lo[3:0]] && res_line[lo[3:0]] == lo) res_v[lo[3:0]] = 1'b0;
            if (res_v[hi[3:0]] && res_line[hi[3:0]] == hi) res_v[hi[3:0]] = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        logic [31:0] ad;
        int op;
        int miss_before;
        for (int i = 0; i < 1048576; i++) ram[i] = 8'($urandom);
        ram_put(32'h10000, 32'h11, 4);
        ram_put(32'h10004, 32'h22, 4);
        ram_put(32'h10008, 32'h33, 4);
        ram_put(32'h1000C, 32'h44, 4);
        ram_put(32'h10100, 32'h55, 4);
        reset_model();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_strobes", 32'({mem_sw, mem_sh, mem_sb}), 32'd0);
        chk("rst_hit", hit_count, 32'd0);
        chk("rst_miss", miss_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_load(32'h10000, got);
        chk("t1_rd", got, 32'h11);
        do_load(32'h10008, got);
        chk("t2_rd", got, 32'h33);

        do_store(0, 32'h10001, 32'hAB);
        do_load(32'h10000, got);
        chk("t3_rd", got, 32'h0000AB11);
        do_store(2, 32'h20000, 32'hCAFE_F00D);
        miss_before = miss_m;
        do_load(32'h20000, got);
        chk("t3_noalloc", 32'(miss_m - miss_before), 32'd1);

        do_load(32'h10002, got);
        do_load(32'h10010, got);
        do_store(1, 32'h1000F, 32'h5A5A);
        miss_before = miss_m;
        do_load(32'h10000, got);
        do_load(32'h10010, got);
        chk("t4_span_inval", 32'(miss_m - miss_before), 32'd2);

        do_store(1, 32'h1000F, 32'h1234);
        miss_before = miss_m;
        do_load(32'h10000, got);
        do_load(32'h10100, got);
        chk("t5_rd", got, 32'h55);
        do_load(32'h10000, got);
        chk("t5_conflict", 32'(miss_m - miss_before), 32'd3);

        @(negedge clk);
        re = 1'b1;
        a  = 32'h10200;
        #1;
        chk("t6_miss_stall", 32'(stall), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_stall", 32'(stall), 32'd0);
        chk("t6_rst_miss", miss_count, 32'd0);
        re = 1'b0;
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        do_load(32'h10200, got);
        chk("t6_reload", 32'(miss_m), 32'd1);

        for (int t = 0; t < 400; t++) begin
            ad = 32'h10000 + $urandom_range(0, 32'h3FF);
            op = $urandom_range(0, 7);
            if (op <= 3) begin
                do_load({ad[31:2], 2'b00}, got);
            end else if (op == 4) begin
                do_load((ad[1:0] == 2'b00) ? (ad | 32'd1) : ad, got);
            end else begin
                do_store(op - 5, ad, $urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
